// File: rtl/sata_cmd_issuer.sv
// sata_cmd_issuer
//   Command-layer engine downstream of the SATA HBA. It takes one ATA command
//   from the user and sends it as a 5-dword Register H2D FIS (type 0x27).
//   A failed transmit is retried up to TX_RETRY extra times. It then waits
//   for the device's Register D2H FIS (0x34) and reports status/error.
//   Payload of any Data FIS (0x46) seen while busy goes to the rdata stream.
//   Only non-data and DMA-in commands are supported.
//
// Optional feature: define SATA_CMD_TIMEOUT_EN to bound the wait for the D2H
//   FIS to TIMEOUT_CYCLES clk cycles (resp_code 3 = TIMEOUT). Without it the
//   engine waits until the D2H FIS arrives or the link drops.
//
// Ports
//   clk, rst              : user clock; synchronous active-high reset
//   link_initialized      : link up indication from the HBA
//   cmd_valid/cmd_ready   : command handshake; cmd_code/features/lba/count/device
//   xfis_tvalid/tlast/tdata, xfis_tready : TX FIS stream to the HBA
//   xfis_done/xfis_err    : per-FIS transmit outcome from the HBA
//   rfis_tvalid/tlast/tdata, rfis_err    : RX FIS stream from the HBA
//   rdata_tvalid/tlast/tdata             : Data FIS payload, no backpressure
//   resp_valid/code/status/error/crcerr  : completion report (code 0 OK,
//                                          1 DEVERR, 2 TXFAIL, 3 TIMEOUT)
//   busy                  : engine not idle
//   state_dbg             : current FSM state, for debug and checkers
//
// Handshake rule: a transfer happens on a rising clk edge where valid and
// ready are both high. Once valid is raised, it and its data hold until that
// edge. The exception is link loss, which aborts the FIS and drops
// xfis_tvalid at once. rdata_* and rfis_* carry no ready.

module sata_cmd_issuer #(
    parameter int          TX_RETRY       = 3,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd150000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        link_initialized,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_code,
    input  logic [15:0] cmd_features,
    input  logic [47:0] cmd_lba,
    input  logic [15:0] cmd_count,
    input  logic [7:0]  cmd_device,
    output logic        xfis_tvalid,
    output logic        xfis_tlast,
    output logic [31:0] xfis_tdata,
    input  logic        xfis_tready,
    input  logic        xfis_done,
    input  logic        xfis_err,
    input  logic        rfis_tvalid,
    input  logic        rfis_tlast,
    input  logic [31:0] rfis_tdata,
    input  logic        rfis_err,
    output logic        rdata_tvalid,
    output logic        rdata_tlast,
    output logic [31:0] rdata_tdata,
    output logic        resp_valid,
    output logic [1:0]  resp_code,
    output logic [7:0]  resp_status,
    output logic [7:0]  resp_error,
    output logic        resp_crcerr,
    output logic        busy,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_WAIT_RSP  = 3'd3,
        S_RESP      = 3'd4
    } state_t;

    localparam logic [1:0] RC_OK      = 2'd0;
    localparam logic [1:0] RC_DEVERR  = 2'd1;
    localparam logic [1:0] RC_TXFAIL  = 2'd2;
    localparam logic [1:0] RC_TIMEOUT = 2'd3;
    localparam logic [7:0] RETRY_MAX  = 8'(TX_RETRY);

    state_t      state, state_next;
    logic [7:0]  code_q, device_q;
    logic [15:0] features_q, count_q;
    logic [47:0] lba_q;
    logic [2:0]  idx;
    logic [7:0]  retry_cnt;
    logic        crcerr;
    logic        hdr_next;   // next rfis beat is an FIS header
    logic        data_fis;   // the FIS in flight is a Data FIS
    logic [1:0]  rc_next;
    logic        accept, beat, is_hdr, is_d2h, d2h_take, fwd, retry, timeout_hit;

`ifdef SATA_CMD_TIMEOUT_EN
    logic [31:0] to_cnt;
    assign timeout_hit = (state == S_WAIT_RSP) && (to_cnt == TIMEOUT_CYCLES - 32'd1);
`else
    assign timeout_hit = 1'b0;
`endif

    assign cmd_ready   = (state == S_IDLE) & link_initialized;
    assign accept      = cmd_valid & cmd_ready;
    assign xfis_tvalid = (state == S_LOAD) & link_initialized;
    assign beat        = xfis_tvalid & xfis_tready;
    assign xfis_tlast  = xfis_tvalid & (idx == 3'd4);
    assign is_hdr      = rfis_tvalid & hdr_next;
    assign is_d2h      = is_hdr & (rfis_tdata[7:0] == 8'h34);
    assign d2h_take    = (state == S_WAIT_RSP) & link_initialized & is_d2h;
    assign fwd         = rfis_tvalid & ~hdr_next & data_fis & (state != S_IDLE);
    assign busy        = (state != S_IDLE);
    assign state_dbg   = state;

    always_comb begin
        xfis_tdata = 32'h0;
        if (state == S_LOAD) begin
            case (idx)
                3'd0:    xfis_tdata = {features_q[7:0], code_q, 8'h80, 8'h27};
                3'd1:    xfis_tdata = {device_q, lba_q[23:0]};
                3'd2:    xfis_tdata = {features_q[15:8], lba_q[47:24]};
                3'd3:    xfis_tdata = {16'h0, count_q};
                default: xfis_tdata = 32'h0;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        rc_next    = RC_OK;
        retry      = 1'b0;
        case (state)
            S_IDLE: if (accept) state_next = S_LOAD;
            S_LOAD: begin
                if (!link_initialized) begin
                    state_next = S_RESP;
                    rc_next    = RC_TXFAIL;
                end else if (beat && idx == 3'd4) begin
                    state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                // Link loss outranks a same-cycle xfis_done.
                if (!link_initialized) begin
                    state_next = S_RESP;
                    rc_next    = RC_TXFAIL;
                end else if (xfis_done) begin
                    if (!xfis_err) begin
                        state_next = S_WAIT_RSP;
                    end else if (retry_cnt < RETRY_MAX) begin
                        retry      = 1'b1;
                        state_next = S_LOAD;
                    end else begin
                        state_next = S_RESP;
                        rc_next    = RC_TXFAIL;
                    end
                end
            end
            S_WAIT_RSP: begin
                // A D2H header wins over a timeout expiring in the same cycle.
                if (!link_initialized) begin
                    state_next = S_RESP;
                    rc_next    = RC_TXFAIL;
                end else if (is_d2h) begin
                    state_next = S_RESP;
                    rc_next    = rfis_tdata[16] ? RC_DEVERR : RC_OK;
                end else if (timeout_hit) begin
                    state_next = S_RESP;
                    rc_next    = RC_TIMEOUT;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            code_q       <= 8'h0;
            device_q     <= 8'h0;
            features_q   <= 16'h0;
            count_q      <= 16'h0;
            lba_q        <= 48'h0;
            idx          <= 3'd0;
            retry_cnt    <= 8'd0;
            crcerr       <= 1'b0;
            hdr_next     <= 1'b1;
            data_fis     <= 1'b0;
            rdata_tvalid <= 1'b0;
            rdata_tlast  <= 1'b0;
            rdata_tdata  <= 32'h0;
            resp_valid   <= 1'b0;
            resp_code    <= RC_OK;
            resp_status  <= 8'h0;
            resp_error   <= 8'h0;
            resp_crcerr  <= 1'b0;
        end else begin
            state <= state_next;

            if (accept) begin
                code_q     <= cmd_code;
                device_q   <= cmd_device;
                features_q <= cmd_features;
                count_q    <= cmd_count;
                lba_q      <= cmd_lba;
                retry_cnt  <= 8'd0;
            end else if (retry) begin
                retry_cnt <= retry_cnt + 8'd1;
            end

            // Index restarts on every (re)entry to LOAD.
            if (state != S_LOAD)  idx <= 3'd0;
            else if (beat)        idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;

            if (accept)                          crcerr <= 1'b0;
            else if (rfis_err && state != S_IDLE) crcerr <= 1'b1;

            // Header tracking runs in every state so IDLE traffic keeps it aligned.
            if (rfis_tvalid) hdr_next <= rfis_tlast;
            if (is_hdr)      data_fis <= (rfis_tdata[7:0] == 8'h46);

            rdata_tvalid <= fwd;
            rdata_tlast  <= fwd & rfis_tlast;
            if (fwd) rdata_tdata <= rfis_tdata;

            resp_valid <= (state_next == S_RESP);
            if (state_next == S_RESP) begin
                resp_code   <= rc_next;
                resp_crcerr <= crcerr | rfis_err;
                resp_status <= d2h_take ? rfis_tdata[23:16] : 8'h0;
                resp_error  <= d2h_take ? rfis_tdata[31:24] : 8'h0;
            end
        end
    end

`ifdef SATA_CMD_TIMEOUT_EN
    // Zero outside WAIT_RSP, so it starts from 0 on every entry.
    always_ff @(posedge clk) begin
        if (rst)                       to_cnt <= 32'd0;
        else if (state == S_WAIT_RSP)  to_cnt <= to_cnt + 32'd1;
        else                           to_cnt <= 32'd0;
    end
`endif

endmodule

// File: tb/tb_sata_cmd_issuer.sv
// Directed bench for sata_cmd_issuer: H2D FIS layout, retries, D2H status,
// Data FIS forwarding, link loss and reset behaviour.
module tb_sata_cmd_issuer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, link_initialized;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_code, cmd_device;
    logic [15:0] cmd_features, cmd_count;
    logic [47:0] cmd_lba;
    logic        xfis_tvalid, xfis_tlast, xfis_tready, xfis_done, xfis_err;
    logic [31:0] xfis_tdata;
    logic        rfis_tvalid, rfis_tlast, rfis_err;
    logic [31:0] rfis_tdata;
    logic        rdata_tvalid, rdata_tlast;
    logic [31:0] rdata_tdata;
    logic        resp_valid, resp_crcerr, busy;
    logic [1:0]  resp_code;
    logic [7:0]  resp_status, resp_error;
    logic [2:0]  state_dbg;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_dw[5];
    logic [32:0] exp_q[$];   // {tlast, data} expected on rdata
    int fwd_cnt;

    sata_cmd_issuer #(.TX_RETRY(3), .TIMEOUT_CYCLES(32'd100)) dut (
        .clk(clk), .rst(rst), .link_initialized(link_initialized),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
        .cmd_features(cmd_features), .cmd_lba(cmd_lba), .cmd_count(cmd_count),
        .cmd_device(cmd_device),
        .xfis_tvalid(xfis_tvalid), .xfis_tlast(xfis_tlast), .xfis_tdata(xfis_tdata),
        .xfis_tready(xfis_tready), .xfis_done(xfis_done), .xfis_err(xfis_err),
        .rfis_tvalid(rfis_tvalid), .rfis_tlast(rfis_tlast), .rfis_tdata(rfis_tdata),
        .rfis_err(rfis_err),
        .rdata_tvalid(rdata_tvalid), .rdata_tlast(rdata_tlast), .rdata_tdata(rdata_tdata),
        .resp_valid(resp_valid), .resp_code(resp_code), .resp_status(resp_status),
        .resp_error(resp_error), .resp_crcerr(resp_crcerr), .busy(busy),
        .state_dbg(state_dbg)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_exp(input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3,
                           input logic [31:0] d4);
        exp_dw[0] = d0; exp_dw[1] = d1; exp_dw[2] = d2; exp_dw[3] = d3; exp_dw[4] = d4;
    endtask

    task automatic do_cmd(input logic [7:0] code, input logic [15:0] feat,
                          input logic [47:0] lba, input logic [15:0] cnt,
                          input logic [7:0] dev);
        cmd_code = code; cmd_features = feat; cmd_lba = lba;
        cmd_count = cnt; cmd_device = dev; cmd_valid = 1'b1;
        check("cmd_ready_idle", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("busy_after_accept", busy, 1);
    endtask

    // Collects one H2D FIS with xfis_tready high; beats must be consecutive.
    task automatic collect_fis(input string tag);
        for (int i = 0; i < 5; i++) begin
            check({tag, "_tvalid"}, xfis_tvalid, 1);
            check($sformatf("%s_dw%0d", tag, i), xfis_tdata, exp_dw[i]);
            check({tag, "_tlast"}, xfis_tlast, (i == 4));
            tick();
        end
    endtask

    task automatic send_done(input logic err);
        xfis_done = 1'b1; xfis_err = err;
        tick();
        xfis_done = 1'b0; xfis_err = 1'b0;
    endtask

    // Sends an n-dword FIS; payload beats are scoreboarded when fwd_exp.
    task automatic send_rfis(input int n, input logic [31:0] hdr, input bit fwd_exp);
        logic [32:0] got;
        fwd_cnt = 0;
        for (int k = 0; k < n; k++) begin
            rfis_tvalid = 1'b1;
            rfis_tlast  = (k == n - 1);
            rfis_tdata  = (k == 0) ? hdr : (32'hA500_0000 + 32'(k));
            if (fwd_exp && k > 0) exp_q.push_back({rfis_tlast, rfis_tdata});
            tick();
            check("rdata_tvalid", rdata_tvalid, (fwd_exp && k > 0));
            if (rdata_tvalid) begin
                fwd_cnt++;
                if (exp_q.size() > 0) begin
                    got = exp_q.pop_front();
                    check("rdata", {rdata_tlast, rdata_tdata}, got);
                end
            end
        end
        rfis_tvalid = 1'b0; rfis_tlast = 1'b0; rfis_tdata = 32'h0;
        check("rdata_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Called in the cycle resp_valid is expected high.
    task automatic resp_check(input string tag, input logic [1:0] code,
                              input bit chk_se, input logic [7:0] status,
                              input logic [7:0] error, input logic crc);
        check({tag, "_resp_valid"}, resp_valid, 1);
        check({tag, "_resp_code"}, resp_code, code);
        check({tag, "_resp_crcerr"}, resp_crcerr, crc);
        if (chk_se) begin
            check({tag, "_resp_status"}, resp_status, status);
            check({tag, "_resp_error"}, resp_error, error);
        end
        tick();
        check({tag, "_resp_pulse"}, resp_valid, 0);
        check({tag, "_idle_ready"}, cmd_ready, 1);
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; link_initialized = 1'b0; cmd_valid = 1'b0;
        cmd_code = 8'h0; cmd_device = 8'h0; cmd_features = 16'h0;
        cmd_count = 16'h0; cmd_lba = 48'h0;
        xfis_tready = 1'b1; xfis_done = 1'b0; xfis_err = 1'b0;
        rfis_tvalid = 1'b0; rfis_tlast = 1'b0; rfis_tdata = 32'h0; rfis_err = 1'b0;
        tick(); tick(); tick();

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_xfis_tvalid", xfis_tvalid, 0);
        check("rst_xfis_tdata", xfis_tdata, 0);
        check("rst_rdata_tvalid", rdata_tvalid, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_code", resp_code, 0);
        check("rst_cmd_ready_nolink", cmd_ready, 0);
        link_initialized = 1'b1;
        #1;
        check("rst_cmd_ready_link", cmd_ready, 1);
        rst = 1'b0;
        tick();

        // A Data FIS while idle is discarded
        send_rfis(4, 32'h0000_0046, 0);

        // Non-data command, with ignored FIS types before the D2H
        set_exp(32'h00E78027, 32'h40000000, 32'h0, 32'h0, 32'h0);
        do_cmd(8'hE7, 16'h0, 48'h0, 16'h0, 8'h40);
        collect_fis("nd");
        send_done(1'b0);
        send_rfis(1, 32'h0000_0039, 0);
        check("nd_ignored_fis", resp_valid, 0);
        send_rfis(1, 32'h0000_0046, 0);
        check("nd_hdr_only_data", resp_valid, 0);
        send_rfis(1, 32'h0050_0034, 0);
        resp_check("nd", 2'd0, 1, 8'h50, 8'h00, 1'b0);

        // Device error with a CRC error pulse
        set_exp(32'h00E08027, 32'hA0000000, 32'h0, 32'h0, 32'h0);
        do_cmd(8'hE0, 16'h0, 48'h0, 16'h0, 8'hA0);
        collect_fis("de");
        send_done(1'b0);
        rfis_err = 1'b1;
        tick();
        rfis_err = 1'b0;
        send_rfis(1, 32'h0451_0034, 0);
        resp_check("de", 2'd1, 1, 8'h51, 8'h04, 1'b1);

        // READ DMA EXT: 129-dword Data FIS gives 128 rdata beats
        set_exp(32'h00258027, 32'h40345678, 32'h00000012, 32'h00000001, 32'h0);
        do_cmd(8'h25, 16'h0, 48'h0000_1234_5678, 16'h1, 8'h40);
        collect_fis("rd");
        send_done(1'b0);
        send_rfis(129, 32'h0000_0046, 1);
        check("rd_beat_count", fwd_cnt, 128);
        send_rfis(1, 32'h0050_0034, 0);
        resp_check("rd", 2'd0, 1, 8'h50, 8'h00, 1'b0);

        // Three transmit errors, success on the fourth attempt
        set_exp(32'h00E78027, 32'h40000000, 32'h0, 32'h0, 32'h0);
        do_cmd(8'hE7, 16'h0, 48'h0, 16'h0, 8'h40);
        for (int a = 0; a < 4; a++) begin
            collect_fis($sformatf("rt%0d", a));
            send_done(a < 3);
            check("rt_no_resp", resp_valid, 0);
        end
        send_rfis(1, 32'h0050_0034, 0);
        resp_check("rt", 2'd0, 1, 8'h50, 8'h00, 1'b0);

        // Four transmit errors give TXFAIL after the fourth done
        do_cmd(8'hE7, 16'h0, 48'h0, 16'h0, 8'h40);
        for (int a = 0; a < 4; a++) begin
            collect_fis($sformatf("tf%0d", a));
            send_done(1'b1);
            if (a < 3) check("tf_no_resp", resp_valid, 0);
        end
        resp_check("tf", 2'd2, 0, 8'h0, 8'h0, 1'b0);

        // Reset during LOAD clears everything the next cycle
        do_cmd(8'hE7, 16'h0, 48'h0, 16'h0, 8'h40);
        tick();
        rst = 1'b1;
        tick();
        check("rl_xfis_tvalid", xfis_tvalid, 0);
        check("rl_xfis_tdata", xfis_tdata, 0);
        check("rl_busy", busy, 0);
        check("rl_resp_code", resp_code, 0);
        check("rl_state", state_dbg, 0);
        rst = 1'b0;
        tick();

        // Link loss during LOAD drops tvalid at once and reports TXFAIL
        do_cmd(8'hE7, 16'h0, 48'h0, 16'h0, 8'h40);
        link_initialized = 1'b0;
        #1;
        check("ll_tvalid_drop", xfis_tvalid, 0);
        tick();
        link_initialized = 1'b1;
        resp_check("ll", 2'd2, 0, 8'h0, 8'h0, 1'b0);

        // tready stall holds data; done together with link loss is TXFAIL
        do_cmd(8'hE7, 16'h0, 48'h0, 16'h0, 8'h40);
        xfis_tready = 1'b0;
        for (int s = 0; s < 2; s++) begin
            tick();
            check("st_tvalid", xfis_tvalid, 1);
            check("st_hold_dw0", xfis_tdata, 32'h00E78027);
        end
        xfis_tready = 1'b1;
        collect_fis("st");
        link_initialized = 1'b0;
        send_done(1'b0);
        link_initialized = 1'b1;
        resp_check("st", 2'd2, 0, 8'h0, 8'h0, 1'b0);

`ifdef SATA_CMD_TIMEOUT_EN
        // No reply: TIMEOUT exactly 100 cycles after entering WAIT_RSP
        begin
            int n;
            do_cmd(8'hE7, 16'h0, 48'h0, 16'h0, 8'h40);
            collect_fis("to");
            send_done(1'b0);
            n = 0;
            while (!resp_valid && n < 200) begin
                tick();
                n++;
            end
            check("to_latency", n, 100);
            resp_check("to", 2'd3, 0, 8'h0, 8'h0, 1'b0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
